// File: rtl/control_unit.sv
// Mini-SRC control sequencer: Moore FSM stepping fetch/execute T-states; CU_SINGLE_STEP_EN adds a Step gate before each T0.
// Latency: every control output is registered, decoded from the next state, so it is valid the cycle the FSM enters that state.
// Backpressure: none; Stop (sampled in T0) or the halt opcode parks the FSM in HALT until clear is asserted.
module control_unit #(
  parameter int MEM_WAIT = 1,
  parameter int OPW      = 5
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
`ifdef CU_SINGLE_STEP_EN
  input  logic        Step,
`endif
  output logic        Run,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIout,
  output logic        LOout,
  output logic        MDRout,
  output logic        In_Portout,
  output logic        Cout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin_low,
  output logic        Zin_high,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        ConIn,
  output logic        outPortenable,
  output logic        inPortenable,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout
);

  localparam int CW = $clog2(MEM_WAIT + 1) + 1;

  localparam logic [OPW-1:0] OP_LD   = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(11);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
  localparam logic [OPW-1:0] OP_BR   = OPW'(19);
  localparam logic [OPW-1:0] OP_JR   = OPW'(20);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(21);
  localparam logic [OPW-1:0] OP_IN   = OPW'(22);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(23);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(24);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(25);
  localparam logic [OPW-1:0] OP_HALT = OPW'(27);

  typedef enum logic [5:0] {
    S_RESET, S_HALT, S_SW, S_T0, S_T1, S_TW, S_T2, S_T3,
    S_A1, S_A2, S_WB, S_BA, S_CZ, S_MA, S_RD, S_MG, S_SM, S_WR,
    S_M1, S_M2, S_M3, S_M4, S_N1, S_B1, S_B2, S_BT, S_BN,
    S_J1, S_JL, S_IN, S_OUT, S_MH, S_ML
  } state_t;

`ifdef CU_SINGLE_STEP_EN
  localparam state_t S_DONE = S_SW;
`else
  localparam state_t S_DONE = S_T0;
`endif

  typedef struct packed {
    logic run, pc_out, zlow_out, zhigh_out, hi_out, lo_out, mdr_out, inport_out, c_out;
    logic mar_in, pc_in, mdr_in, ir_in, y_in, zlow_in, zhigh_in, hi_in, lo_in;
    logic inc_pc, rd, wr, con_in, outport_en, inport_en;
    logic gra, grb, grc, r_in, r_out, ba_out;
  } ctrl_t;

  state_t          state, nxt;
  logic [CW-1:0]   wcnt, wnxt;
  ctrl_t           ctrl_q;
  logic [OPW-1:0]  op;
  logic            is_alu, is_imm;
  logic            unused_ir_bits;

  assign op             = IR[31 -: OPW];
  assign unused_ir_bits = ^IR[31-OPW:0];
  assign is_alu         = (op >= OP_ADD) && (op <= OP_ROL);
  assign is_imm         = (op >= OP_ADDI) && (op <= OP_ORI);

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    c.run       = (s != S_RESET) && (s != S_HALT);
    c.inport_en = c.run;
    case (s)
      S_T0:  begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.zlow_in = 1'b1; end
      S_T1:  begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.rd = 1'b1; c.mdr_in = 1'b1; end
      S_TW,
      S_RD:  begin c.rd = 1'b1; c.mdr_in = 1'b1; end
      S_T2:  begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_A1:  begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
      S_A2:  begin c.grc = 1'b1; c.r_out = 1'b1; c.zlow_in = 1'b1; end
      S_WB:  begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      S_BA:  begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
      S_CZ:  begin c.c_out = 1'b1; c.zlow_in = 1'b1; end
      S_MA:  begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
      S_MG:  begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      S_SM:  begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
      S_WR:  c.wr = 1'b1;
      S_M1:  begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
      S_M2:  begin c.grb = 1'b1; c.r_out = 1'b1; c.zlow_in = 1'b1; c.zhigh_in = 1'b1; end
      S_M3:  begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
      S_M4:  begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
      S_N1:  begin c.grb = 1'b1; c.r_out = 1'b1; c.zlow_in = 1'b1; end
      S_B1:  begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
      S_B2:  begin c.pc_out = 1'b1; c.y_in = 1'b1; end
      S_BT:  begin c.zlow_out = 1'b1; c.pc_in = 1'b1; end
      S_J1:  begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
      S_JL:  begin c.pc_out = 1'b1; c.grb = 1'b1; c.r_in = 1'b1; end
      S_IN:  begin c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      S_OUT: begin c.gra = 1'b1; c.r_out = 1'b1; c.outport_en = 1'b1; end
      S_MH:  begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      S_ML:  begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  // IR is stable from T2 until the next fetch, so every execute state may steer on op.
  always_comb begin
    nxt  = state;
    wnxt = wcnt;
    case (state)
      S_RESET: nxt = S_DONE;
`ifdef CU_SINGLE_STEP_EN
      S_SW:    if (Step) nxt = S_T0;
`endif
      S_T0:    nxt = Stop ? S_HALT : S_T1;
      S_T1:    begin nxt = S_TW; wnxt = CW'(MEM_WAIT - 1); end
      S_TW:    if (wcnt == '0) nxt = S_T2; else wnxt = wcnt - CW'(1);
      S_T2:    nxt = S_T3;
      S_T3: begin
        if (is_alu || is_imm) nxt = S_A1;
        else begin
          case (op)
            OP_LD, OP_LDI, OP_ST: nxt = S_BA;
            OP_MUL, OP_DIV:       nxt = S_M1;
            OP_NEG, OP_NOT:       nxt = S_N1;
            OP_BR:                nxt = S_B1;
            OP_JR:                nxt = S_J1;
            OP_JAL:               nxt = S_JL;
            OP_IN:                nxt = S_IN;
            OP_OUT:               nxt = S_OUT;
            OP_MFHI:              nxt = S_MH;
            OP_MFLO:              nxt = S_ML;
            OP_HALT:              nxt = S_HALT;
            default:              nxt = S_DONE;
          endcase
        end
      end
      S_A1:    nxt = is_alu ? S_A2 : S_CZ;
      S_A2:    nxt = S_WB;
      S_BA:    nxt = S_CZ;
      S_CZ: begin
        if (op == OP_BR)                      nxt = CON ? S_BT : S_BN;
        else if (op == OP_LD || op == OP_ST)  nxt = S_MA;
        else                                  nxt = S_WB;
      end
      S_MA: begin
        if (op == OP_LD) begin nxt = S_RD; wnxt = CW'(MEM_WAIT); end
        else nxt = S_SM;
      end
      S_RD:    if (wcnt == '0) nxt = S_MG; else wnxt = wcnt - CW'(1);
      S_SM:    nxt = S_WR;
      S_M1:    nxt = S_M2;
      S_M2:    nxt = S_M3;
      S_M3:    nxt = S_M4;
      S_N1:    nxt = S_WB;
      S_B1:    nxt = S_B2;
      S_B2:    nxt = S_CZ;
      S_JL:    nxt = S_J1;
      S_WB, S_MG, S_WR, S_M4, S_BT, S_BN,
      S_J1, S_IN, S_OUT, S_MH, S_ML: nxt = S_DONE;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_RESET;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state  <= S_RESET;
      wcnt   <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= nxt;
      wcnt   <= wnxt;
      ctrl_q <= decode(nxt);
    end
  end

  assign Run           = ctrl_q.run;
  assign PCout         = ctrl_q.pc_out;
  assign Zlowout       = ctrl_q.zlow_out;
  assign Zhighout      = ctrl_q.zhigh_out;
  assign HIout         = ctrl_q.hi_out;
  assign LOout         = ctrl_q.lo_out;
  assign MDRout        = ctrl_q.mdr_out;
  assign In_Portout    = ctrl_q.inport_out;
  assign Cout          = ctrl_q.c_out;
  assign MARin         = ctrl_q.mar_in;
  assign PCin          = ctrl_q.pc_in;
  assign MDRin         = ctrl_q.mdr_in;
  assign IRin          = ctrl_q.ir_in;
  assign Yin           = ctrl_q.y_in;
  assign Zin_low       = ctrl_q.zlow_in;
  assign Zin_high      = ctrl_q.zhigh_in;
  assign HIin          = ctrl_q.hi_in;
  assign LOin          = ctrl_q.lo_in;
  assign IncPC         = ctrl_q.inc_pc;
  assign Read          = ctrl_q.rd;
  assign Write         = ctrl_q.wr;
  assign ConIn         = ctrl_q.con_in;
  assign outPortenable = ctrl_q.outport_en;
  assign inPortenable  = ctrl_q.inport_en;
  assign Gra           = ctrl_q.gra;
  assign Grb           = ctrl_q.grb;
  assign Grc           = ctrl_q.grc;
  assign Rin           = ctrl_q.r_in;
  assign Rout          = ctrl_q.r_out;
  assign BAout         = ctrl_q.ba_out;

endmodule
